// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N:1 stream funnel.
package stream_mux_pkg;

   localparam int unsigned MUX_MODE_SEL = 0;
   localparam int unsigned MUX_MODE_RR  = 1;

   // Channel-index width, never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N-1.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned SW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] idx,
   output logic          any
);

   int unsigned c;

   // Walk offsets from far to near so the nearest requester wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         c = 32'(ptr) + unsigned'(k);
         if (c >= N) c = c - N;
         if (req[SW'(c)]) begin
            gnt          = '0;
            gnt[SW'(c)]  = 1'b1;
            idx          = SW'(c);
            any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_arb.sv
// N:1 valid/ready stream funnel with one registered output stage, select or round-robin steering.
// Optional packet lock (In_Last/Out_Last) enabled by STREAM_MUX_ARB_LOCK_EN.
module stream_mux_arb
   import stream_mux_pkg::*;
#(
   parameter  int unsigned N    = 4,
   parameter  int unsigned W    = 8,
   parameter  int unsigned MODE = MUX_MODE_SEL,
   localparam int unsigned SW   = sel_width(N)
) (
   input  logic           Clock,
   input  logic           Reset_n,
   input  logic [N*W-1:0] In_Data,
   input  logic [N-1:0]   In_Valid,
   output logic [N-1:0]   In_Ready,
`ifdef STREAM_MUX_ARB_LOCK_EN
   input  logic [N-1:0]   In_Last,
   output logic           Out_Last,
`endif
   input  logic [SW-1:0]  Select_Line,
   output logic [W-1:0]   Out_Data,
   output logic [SW-1:0]  Out_Chan,
   output logic           Out_Valid,
   input  logic           Out_Ready,
   output logic           Sel_Error
);

   logic          load, transfer, grant_valid, base_valid, in_range, sel_err_set;
   logic [N-1:0]  oh, base_oh;
   logic [SW-1:0] g, base_g;
   logic [W-1:0]  sel_data;

   assign load = !Out_Valid || Out_Ready;

   generate
      if (MODE == MUX_MODE_RR) begin : g_rr
         logic [SW-1:0] ptr_q;

         rr_arbiter #(.N(N), .SW(SW)) u_arb (
            .req (In_Valid),
            .ptr (ptr_q),
            .gnt (base_oh),
            .idx (base_g),
            .any (base_valid)
         );
         assign in_range = 1'b1;

         // Pointer wraps explicitly at N-1 so non-power-of-2 N works.
         always_ff @(posedge Clock) begin
            if (!Reset_n) begin
               ptr_q <= '0;
`ifdef STREAM_MUX_ARB_LOCK_EN
            end else if (transfer && |(oh & In_Last)) begin
`else
            end else if (transfer) begin
`endif
               ptr_q <= (g == SW'(N - 1)) ? '0 : g + 1'b1;
            end
         end
      end else begin : g_sel
         assign base_g   = Select_Line;
         assign in_range = 32'(Select_Line) < N;

         always_comb begin
            base_oh = '0;
            for (int unsigned i = 0; i < N; i++)
               if (Select_Line == SW'(i)) base_oh[i] = 1'b1;
         end
         assign base_valid = |(base_oh & In_Valid);
      end
   endgenerate

`ifdef STREAM_MUX_ARB_LOCK_EN
   logic          lock_q, sel_last;
   logic [N-1:0]  lock_oh_q;
   logic [SW-1:0] lock_chan_q;

   assign oh          = lock_q ? lock_oh_q : base_oh;
   assign g           = lock_q ? lock_chan_q : base_g;
   assign grant_valid = lock_q ? |(lock_oh_q & In_Valid) : base_valid;
   assign sel_last    = |(oh & In_Last);
   assign sel_err_set = !in_range && (|In_Valid) && !lock_q;

   // Hold the grant on the current channel until its last word transfers.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         lock_q      <= 1'b0;
         lock_oh_q   <= '0;
         lock_chan_q <= '0;
         Out_Last    <= 1'b0;
      end else if (transfer) begin
         lock_q      <= !sel_last;
         lock_oh_q   <= oh;
         lock_chan_q <= g;
         Out_Last    <= sel_last;
      end
   end
`else
   assign oh          = base_oh;
   assign g           = base_g;
   assign grant_valid = base_valid;
   assign sel_err_set = !in_range && (|In_Valid);
`endif

   assign transfer = Reset_n && load && grant_valid;
   assign In_Ready = transfer ? oh : '0;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N; i++)
         if (oh[i]) sel_data = sel_data | In_Data[i*W +: W];
   end

   // Output stage: load on transfer, drain when nothing is granted, hold on stall.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         Out_Data  <= '0;
         Out_Chan  <= '0;
         Out_Valid <= 1'b0;
         Sel_Error <= 1'b0;
      end else begin
         if (transfer) begin
            Out_Data  <= sel_data;
            Out_Chan  <= g;
            Out_Valid <= 1'b1;
         end else if (load) begin
            Out_Valid <= 1'b0;
         end
         if (sel_err_set) Sel_Error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: select mode (N=4, N=3) and round-robin mode (N=4).
module tb_stream_mux_arb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   logic [31:0] s4_data;  logic [3:0] s4_valid, s4_ready; logic [1:0] s4_sel;
   logic [7:0]  s4_odata; logic [1:0] s4_ochan; logic s4_ovalid, s4_oready, s4_err;

   logic [23:0] s3_data;  logic [2:0] s3_valid, s3_ready; logic [1:0] s3_sel;
   logic [7:0]  s3_odata; logic [1:0] s3_ochan; logic s3_ovalid, s3_oready, s3_err;

   logic [31:0] rr_data;  logic [3:0] rr_valid, rr_ready; logic [1:0] rr_sel;
   logic [7:0]  rr_odata; logic [1:0] rr_ochan; logic rr_ovalid, rr_oready, rr_err;

`ifdef STREAM_MUX_ARB_LOCK_EN
   logic [3:0] s4_last = '1;
   logic [2:0] s3_last = '1;
   logic [3:0] rr_last = '1;
   logic       s4_olast, s3_olast, rr_olast;
`endif

   stream_mux_arb #(.N(4), .W(8), .MODE(0)) u_sel4 (
      .Clock(clk), .Reset_n(rst_n), .In_Data(s4_data), .In_Valid(s4_valid), .In_Ready(s4_ready),
`ifdef STREAM_MUX_ARB_LOCK_EN
      .In_Last(s4_last), .Out_Last(s4_olast),
`endif
      .Select_Line(s4_sel), .Out_Data(s4_odata), .Out_Chan(s4_ochan), .Out_Valid(s4_ovalid),
      .Out_Ready(s4_oready), .Sel_Error(s4_err));

   stream_mux_arb #(.N(3), .W(8), .MODE(0)) u_sel3 (
      .Clock(clk), .Reset_n(rst_n), .In_Data(s3_data), .In_Valid(s3_valid), .In_Ready(s3_ready),
`ifdef STREAM_MUX_ARB_LOCK_EN
      .In_Last(s3_last), .Out_Last(s3_olast),
`endif
      .Select_Line(s3_sel), .Out_Data(s3_odata), .Out_Chan(s3_ochan), .Out_Valid(s3_ovalid),
      .Out_Ready(s3_oready), .Sel_Error(s3_err));

   stream_mux_arb #(.N(4), .W(8), .MODE(1)) u_rr4 (
      .Clock(clk), .Reset_n(rst_n), .In_Data(rr_data), .In_Valid(rr_valid), .In_Ready(rr_ready),
`ifdef STREAM_MUX_ARB_LOCK_EN
      .In_Last(rr_last), .Out_Last(rr_olast),
`endif
      .Select_Line(rr_sel), .Out_Data(rr_odata), .Out_Chan(rr_ochan), .Out_Valid(rr_ovalid),
      .Out_Ready(rr_oready), .Sel_Error(rr_err));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      s4_valid = 4'hF; s4_oready = 1'b1; s4_sel = 2'd0;
      rr_valid = 4'hF; rr_oready = 1'b1;
      #1;
      n_checks++; if (s4_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_s4_ready got=%b exp=0000", s4_ready); end
      n_checks++; if (rr_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_rr_ready got=%b exp=0000", rr_ready); end
      tick; tick;
      n_checks++; if (s4_ovalid !== 1'b0 || s4_odata !== 8'h00 || s4_ochan !== 2'd0 || s4_err !== 1'b0) begin
         n_bad++; $display("FAIL reset_s4_out got v=%b d=%h c=%0d e=%b exp 0/00/0/0", s4_ovalid, s4_odata, s4_ochan, s4_err); end
      n_checks++; if (s3_ovalid !== 1'b0 || s3_odata !== 8'h00 || s3_err !== 1'b0) begin
         n_bad++; $display("FAIL reset_s3_out got v=%b d=%h e=%b exp 0/00/0", s3_ovalid, s3_odata, s3_err); end
      n_checks++; if (rr_ovalid !== 1'b0 || rr_odata !== 8'h00 || rr_ochan !== 2'd0) begin
         n_bad++; $display("FAIL reset_rr_out got v=%b d=%h c=%0d exp 0/00/0", rr_ovalid, rr_odata, rr_ochan); end
      s4_valid = 4'h0; rr_valid = 4'h0;
      rst_n = 1'b1;
   endtask

   task automatic test_select;
      logic [7:0] exp_d;
      s4_valid = 4'hF; s4_oready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         s4_sel = 2'(s);
         #1;
         n_checks++; if (s4_ready !== (4'b0001 << s)) begin n_bad++; $display("FAIL sel_ready s=%0d got=%b exp=%b", s, s4_ready, 4'b0001 << s); end
         tick;
         exp_d = 8'((s + 1) * 17);
         n_checks++; if (s4_ovalid !== 1'b1 || s4_odata !== exp_d || s4_ochan !== 2'(s)) begin
            n_bad++; $display("FAIL sel_out s=%0d got v=%b d=%h c=%0d exp 1/%h/%0d", s, s4_ovalid, s4_odata, s4_ochan, exp_d, s); end
      end
      s4_valid = 4'h0;
      #1;
      n_checks++; if (s4_ready !== 4'b0000) begin n_bad++; $display("FAIL drain_ready got=%b exp=0000", s4_ready); end
      tick;
      n_checks++; if (s4_ovalid !== 1'b0 || s4_odata !== 8'h44 || s4_ochan !== 2'd3) begin
         n_bad++; $display("FAIL drain_hold got v=%b d=%h c=%0d exp 0/44/3", s4_ovalid, s4_odata, s4_ochan); end
   endtask

   task automatic test_sel_error;
      s3_valid = 3'b111; s3_oready = 1'b1; s3_sel = 2'd1;
      tick;
      n_checks++; if (s3_ovalid !== 1'b1 || s3_odata !== 8'h22 || s3_err !== 1'b0) begin
         n_bad++; $display("FAIL s3_sel1 got v=%b d=%h e=%b exp 1/22/0", s3_ovalid, s3_odata, s3_err); end
      s3_sel = 2'd3;
      #1;
      n_checks++; if (s3_ready !== 3'b000) begin n_bad++; $display("FAIL s3_oor_ready got=%b exp=000", s3_ready); end
      tick;
      n_checks++; if (s3_ovalid !== 1'b0 || s3_err !== 1'b1 || s3_odata !== 8'h22) begin
         n_bad++; $display("FAIL s3_oor_out got v=%b e=%b d=%h exp 0/1/22", s3_ovalid, s3_err, s3_odata); end
      s3_sel = 2'd0;
      tick;
      n_checks++; if (s3_ovalid !== 1'b1 || s3_odata !== 8'h11 || s3_err !== 1'b1) begin
         n_bad++; $display("FAIL s3_sticky got v=%b d=%h e=%b exp 1/11/1", s3_ovalid, s3_odata, s3_err); end
      s3_valid = 3'b000; s3_sel = 2'd3;
      tick;
      n_checks++; if (s3_err !== 1'b1 || s3_ovalid !== 1'b0) begin n_bad++; $display("FAIL s3_sticky_idle got e=%b v=%b exp 1/0", s3_err, s3_ovalid); end
      rst_n = 1'b0;
      tick;
      n_checks++; if (s3_err !== 1'b0) begin n_bad++; $display("FAIL s3_err_clear got=%b exp=0", s3_err); end
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_c;
      rr_valid = 4'hF; rr_oready = 1'b1;
      #1;
      n_checks++; if (rr_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_first_ready got=%b exp=0001", rr_ready); end
      for (int k = 0; k < 8; k++) begin
         tick;
         exp_c = 2'(k % 4);
         n_checks++; if (rr_ovalid !== 1'b1 || rr_ochan !== exp_c || rr_odata !== 8'((exp_c + 1) * 17)) begin
            n_bad++; $display("FAIL rr_all k=%0d got c=%0d d=%h v=%b exp c=%0d", k, rr_ochan, rr_odata, rr_ovalid, exp_c); end
      end
      rr_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick;
         exp_c = (k % 2 == 0) ? 2'd1 : 2'd3;
         n_checks++; if (rr_ochan !== exp_c || rr_odata !== 8'((exp_c + 1) * 17)) begin
            n_bad++; $display("FAIL rr_1010 k=%0d got c=%0d d=%h exp c=%0d", k, rr_ochan, rr_odata, exp_c); end
      end
   endtask

   task automatic test_backpressure;
      rr_valid = 4'hF; rr_oready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++; if (rr_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready k=%0d got=%b exp=0000", k, rr_ready); end
         tick;
         n_checks++; if (rr_ovalid !== 1'b1 || rr_ochan !== 2'd3 || rr_odata !== 8'h44) begin
            n_bad++; $display("FAIL bp_hold k=%0d got v=%b c=%0d d=%h exp 1/3/44", k, rr_ovalid, rr_ochan, rr_odata); end
      end
      rr_oready = 1'b1;
      #1;
      n_checks++; if (rr_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_release_ready got=%b exp=0001", rr_ready); end
      tick;
      n_checks++; if (rr_ovalid !== 1'b1 || rr_ochan !== 2'd0 || rr_odata !== 8'h11) begin
         n_bad++; $display("FAIL bp_next got v=%b c=%0d d=%h exp 1/0/11", rr_ovalid, rr_ochan, rr_odata); end
      tick;
      n_checks++; if (rr_ovalid !== 1'b1 || rr_ochan !== 2'd1 || rr_odata !== 8'h22) begin
         n_bad++; $display("FAIL bp_follow got v=%b c=%0d d=%h exp 1/1/22", rr_ovalid, rr_ochan, rr_odata); end
   endtask

   task automatic test_reset_mid;
      rst_n = 1'b0;
      #1;
      n_checks++; if (rr_ready !== 4'b0000) begin n_bad++; $display("FAIL rmid_ready got=%b exp=0000", rr_ready); end
      tick;
      n_checks++; if (rr_ovalid !== 1'b0 || rr_odata !== 8'h00 || rr_ochan !== 2'd0) begin
         n_bad++; $display("FAIL rmid_out got v=%b d=%h c=%0d exp 0/00/0", rr_ovalid, rr_odata, rr_ochan); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (rr_ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_ptr_ready got=%b exp=0001", rr_ready); end
      tick;
      n_checks++; if (rr_ovalid !== 1'b1 || rr_ochan !== 2'd0 || rr_odata !== 8'h11) begin
         n_bad++; $display("FAIL rmid_first got v=%b c=%0d d=%h exp 1/0/11", rr_ovalid, rr_ochan, rr_odata); end
   endtask

`ifdef STREAM_MUX_ARB_LOCK_EN
   task automatic test_lock;
      rr_valid = 4'b0001; rr_last = 4'b0001;
      tick;
      rr_valid = 4'b0111; rr_data = 32'h4433A111;
      for (int k = 0; k < 3; k++) begin
         rr_data[15:8] = 8'(8'hA1 + k);
         if (k == 2) rr_last = 4'b0011;
         #1;
         n_checks++; if (rr_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_ready k=%0d got=%b exp=0010", k, rr_ready); end
         tick;
         n_checks++; if (rr_ochan !== 2'd1 || rr_odata !== 8'(8'hA1 + k) || rr_olast !== (k == 2)) begin
            n_bad++; $display("FAIL lock_word k=%0d got c=%0d d=%h l=%b", k, rr_ochan, rr_odata, rr_olast); end
      end
      rr_last = 4'b0001;
      tick;
      n_checks++; if (rr_ochan !== 2'd2 || rr_odata !== 8'h33 || rr_olast !== 1'b0) begin
         n_bad++; $display("FAIL lock_after got c=%0d d=%h l=%b exp 2/33/0", rr_ochan, rr_odata, rr_olast); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      s4_data = 32'h44332211; s4_valid = '0; s4_sel = '0; s4_oready = 1'b1;
      s3_data = 24'h332211;   s3_valid = '0; s3_sel = '0; s3_oready = 1'b1;
      rr_data = 32'h44332211; rr_valid = '0; rr_sel = '0; rr_oready = 1'b1;
      test_reset;
      test_select;
      test_sel_error;
      test_round_robin;
      test_backpressure;
      test_reset_mid;
`ifdef STREAM_MUX_ARB_LOCK_EN
      test_lock;
`endif
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor of the 4:1 behavioural mux: N channels, W-bit data, valid/ready handshake, one registered output stage.
- Two modes:
  - MODE=0: the external select line steers the output.
  - MODE=1: internal round-robin arbiter steers the output.
- Sits between multiple producers and a single consumer.
- Forms the team's standard N:1 stream funnel.

Parameters:
- N, 4: number of input channels, N >= 2.
- W, 8: data width per channel.
- MODE, 0: 0 = external select, 1 = round-robin.
- SW, $clog2(N): select/channel-index width (localparam, minimum 1).

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset, sampled on rising edge of Clock.
- In_Data  in  N*W  channel i occupies bits [i*W +: W].
- In_Valid  in  N  per-channel valid.
- In_Ready  out  N  per-channel ready (combinational).
- Select_Line  in  SW  channel select; used only when MODE=0.
- Out_Data  out  W  registered data.
- Out_Chan  out  SW  registered index of the source channel.
- Out_Valid  out  1  registered valid.
- Out_Ready  in  1  consumer ready.
- Sel_Error  out  1  sticky flag: an out-of-range Select_Line was seen while some In_Valid was high (MODE=0 only).

Behaviour:
- Reset (Reset_n=0 at an edge):
  - Out_Valid=0, Out_Data=0, Out_Chan=0, Sel_Error=0, rr pointer=0, lock state cleared.
  - In_Ready=0 while Reset_n=0.
- Accept condition: load = !Out_Valid || Out_Ready. Sustains 1 transfer/cycle.
- Grant g (combinational):
  - MODE=0: g = Select_Line.
    - Grant is valid only if Select_Line < N and In_Valid[g]=1.
    - If Select_Line >= N: no grant, all In_Ready=0.
    - Sel_Error is set on the next edge if any In_Valid=1 in that cycle.
  - MODE=1: first i with In_Valid[i]=1, searching ptr, ptr+1, …, wrapping modulo N.
- Ready generation:
  - In_Ready[i] = load && grant_valid && (i==g).
  - Exactly zero or one bit of In_Ready is high.
- Transfer on channel g occurs when In_Valid[g] && In_Ready[g]. At that edge:
  - Out_Data <= In_Data[g]
  - Out_Chan <= g
  - Out_Valid <= 1
  - MODE=1: ptr <= (g==N-1) ? 0 : g+1
- Drain: if load=1 and no grant, Out_Valid <= 0 at the next edge.
  - Out_Data and Out_Chan hold their last values.
- Stall: while Out_Valid=1 && Out_Ready=0, Out_* are held stable and all In_Ready=0.
- Latency: one cycle from input handshake to Out_Valid.
- Round-robin fairness: each requesting channel is granted within N grants.
- Non-power-of-2 N: pointer wrap is explicit at N-1, never relies on SW overflow.
- Reset mid-transfer: pending output word is discarded; no In_Ready is asserted in the reset cycle.
- Sel_Error is cleared only by reset.

Optional Feature:
- Macro: STREAM_MUX_ARB_LOCK_EN.
- Defined:
  - Adds port In_Last (in, N) and port Out_Last (out, 1, registered, reset 0).
  - After a transfer with In_Last[g]=0, the grant is locked to g until a transfer with In_Last[g]=1 completes.
  - In MODE=0, Select_Line is ignored while locked.
  - In MODE=1, the pointer does not advance until the packet's last word.
  - Reset clears the lock.
- Undefined:
  - No In_Last/Out_Last ports.
  - Every word is an independent grant.

Decomposition:
- Package stream_mux_pkg holds:
  - the mode constants MUX_MODE_SEL=0 and MUX_MODE_RR=1;
  - a function computing SW with minimum 1.
- One natural sub-module, rr_arbiter:
  - inputs: N-bit request, pointer;
  - outputs: one-hot grant, encoded index, any-grant.
  - Combinational; instantiated only when MODE=1.

Test Plan:
- MODE=0, N=4, W=8; In_Data={8'h44,8'h33,8'h22,8'h11}, all valid, Out_Ready=1; Select_Line 0,1,2,3 → Out_Data 11,22,33,44 one cycle later, Out_Chan 0..3.
- MODE=0, N=3, Select_Line=3 with In_Valid=3'b111 → In_Ready=0, Out_Valid drops, Sel_Error=1 and stays until Reset_n=0.
- MODE=1, N=4, all valid, Out_Ready=1 for 8 cycles → Out_Chan sequence 0,1,2,3,0,1,2,3; In_Valid=4'b1010 → 1,3,1,3.
- Backpressure: Out_Ready=0 for 3 cycles with Out_Valid=1 → Out_Data/Out_Chan stable, In_Ready=0; Out_Ready=1 → next word follows with no bubble.
- Reset_n=0 for one cycle mid-stream with Out_Valid=1 → next cycle Out_Valid=0, Out_Data=0, ptr=0 (next RR grant is channel 0 when all valid).
- With STREAM_MUX_ARB_LOCK_EN, MODE=1: ch1 sends 3 words (Last on 3rd) while ch0/ch2 valid → Out_Chan 1,1,1, then 2; Out_Last=1 only on the third word.
